// File: rtl/aes_pkg.sv
// Purpose: shared mode/state types, last-round constants and lookup for the AES round sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_pkg;

  // Key-length selection as driven to aes_rounddata; 11 is an alias of AES-256.
  typedef enum logic [1:0] {
    AES_128     = 2'b00,
    AES_192     = 2'b01,
    AES_256     = 2'b10,
    AES_256_ALT = 2'b11
  } aes_mode_t;

  localparam logic [3:0] LAST_ROUND_128 = 4'd10;
  localparam logic [3:0] LAST_ROUND_192 = 4'd12;
  localparam logic [3:0] LAST_ROUND_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARK0 = 2'b01,
    SUB  = 2'b10,
    CAPT = 2'b11
  } aes_seq_state_t;

  function automatic logic [3:0] last_round(input aes_mode_t mode);
    case (mode)
      AES_128: return LAST_ROUND_128;
      AES_192: return LAST_ROUND_192;
      default: return LAST_ROUND_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_seq_counter.sv
// Purpose: round / width_sel counter pair with clear, increment and terminal-count flags.
// Latency: counts update one edge after clr/inc; terminal counts are combinational on the flops.
// Backpressure: none; the owning FSM decides when to increment.
// Ports: clk, reset (sync, active-high); clr zeroes both counters and wins over the increments;
//   rnd_inc/ws_inc advance round/width_sel; last_rnd is the round index that raises rnd_tc;
//   ws_tc is high while width_sel holds the final sub-cycle index.
module aes_seq_counter
  import aes_pkg::*;
#(
  parameter int SUB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       rnd_inc,
  input  logic       ws_inc,
  input  logic [3:0] last_rnd,
  output logic [3:0] round,
  output logic [3:0] width_sel,
  output logic       ws_tc,
  output logic       rnd_tc
);

  localparam logic [3:0] WS_LAST = 4'(SUB_CYCLES - 1);

  logic [3:0] round_q, round_d;
  logic [3:0] width_sel_q, width_sel_d;

  assign round     = round_q;
  assign width_sel = width_sel_q;
  assign ws_tc     = (width_sel_q == WS_LAST);
  assign rnd_tc    = (round_q == last_rnd);

  always_comb begin
    round_d     = round_q;
    width_sel_d = width_sel_q;
    if (clr) begin
      round_d     = 4'd0;
      width_sel_d = 4'd0;
    end else begin
      if (rnd_inc) round_d = round_q + 4'd1;
      // The sub-cycle sweep is the only counter that wraps.
      if (ws_inc)  width_sel_d = ws_tc ? 4'd0 : width_sel_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_q     <= 4'd0;
      width_sel_q <= 4'd0;
    end else begin
      round_q     <= round_d;
      width_sel_q <= width_sel_d;
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Purpose: AES state register + round FSM feeding aes_rounddata (ARK0, then SUB sweep + CAPT per round).
// Latency: accept edge to done pulse = 1 + last_round*(SUB_CYCLES+1) cycles (171/205/239).
// Backpressure: ready only in IDLE; start while busy is dropped, no queueing.
// Ports: start/mode/plaintext in (sampled on accept), rd_data_out in from aes_rounddata;
//   rd_data_in/round/width_sel/mode_q out to aes_rounddata; ready/busy/done/ciphertext status.
// Option: define AES_SEQ_ABORT_EN to add an 'abort' input that returns to IDLE without done.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int SUB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_SEQ_ABORT_EN
  input  logic         abort,
`endif
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [127:0] plaintext,
  input  logic [127:0] rd_data_out,
  output logic [127:0] rd_data_in,
  output logic [3:0]   round,
  output logic [3:0]   width_sel,
  output logic [1:0]   mode_q,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  aes_seq_state_t state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   ct_q, ct_d;
  logic [1:0]     mode_d;
  logic           done_q, done_d;

  logic cnt_clr, rnd_inc, ws_inc, ws_tc, rnd_tc;

  aes_seq_counter #(
    .SUB_CYCLES(SUB_CYCLES)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .rnd_inc  (rnd_inc),
    .ws_inc   (ws_inc),
    .last_rnd (last_round(aes_mode_t'(mode_q))),
    .round    (round),
    .width_sel(width_sel),
    .ws_tc    (ws_tc),
    .rnd_tc   (rnd_tc)
  );

  assign rd_data_in = data_q;
  assign ciphertext = ct_q;
  assign done       = done_q;
  assign ready      = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    rnd_inc = 1'b0;
    ws_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = plaintext;
          mode_d  = mode;
          cnt_clr = 1'b1;
          state_d = ARK0;
        end
      end
      ARK0: begin
        // Initial AddRoundKey result comes straight back from aes_rounddata.
        data_d  = rd_data_out;
        rnd_inc = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        // State is held while aes_rounddata walks the bytes.
        ws_inc = 1'b1;
        if (ws_tc) state_d = CAPT;
      end
      CAPT: begin
        data_d = rd_data_out;
        if (rnd_tc) begin
          ct_d    = rd_data_out;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rnd_inc = 1'b1;
          state_d = SUB;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_SEQ_ABORT_EN
    // Abort drops the block: no done, ciphertext untouched, counters zeroed.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      data_d  = data_q;
      ct_d    = ct_q;
      done_d  = 1'b0;
      cnt_clr = 1'b1;
      rnd_inc = 1'b0;
      ws_inc  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= 2'b00;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

endmodule
